bist_response_analyzer: RTL and testbench

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

---
 rtl/bist_response_analyzer.sv | 122 ++++++++++++
 tb/tb_bist_response_analyzer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer.sv
// BIST output-response analyzer: compacts full-adder CUT responses into an 8-bit MISR and grades the run.
// Optional macro BIST_ORA_CMP_EN adds a per-pattern golden-compare error counter to the verdict.
module bist_response_analyzer #(
    parameter int          NUM_PATTERNS = 8,
    parameter logic [7:0]  SIG_SEED     = 8'hFF,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pat_valid,
    input  logic       sum,
    input  logic       cout,
    input  logic       exp_sum,
    input  logic       exp_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [7:0] signature,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_t;

    localparam logic [3:0] LAST_PAT = 4'(NUM_PATTERNS - 1);

    state_t     state_q, state_d;
    logic [7:0] sig_q, sig_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;

    logic [7:0] misr_next;
    logic [3:0] err_upd;
    logic       verdict;

    // Feedback taps x^8 + x^6 + x^5 + x^4 feed bit 0; carry is injected at bit 1.
    assign misr_next[0] = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3] ^ sum;
    assign misr_next[1] = sig_q[0] ^ cout;
    generate
        for (genvar gi = 2; gi < 8; gi++) begin : g_shift
            assign misr_next[gi] = sig_q[gi-1];
        end
    endgenerate

`ifdef BIST_ORA_CMP_EN
    logic mismatch;
    assign mismatch = ({sum, cout} != {exp_sum, exp_cout});
    assign err_upd  = (mismatch && (err_q != 4'hF)) ? err_q + 4'd1 : err_q;
`else
    logic unused_exp;
    assign unused_exp = exp_sum ^ exp_cout;
    assign err_upd    = 4'd0;
`endif

    assign verdict = (sig_q == GOLDEN_SIG) && (err_q == 4'd0);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COMPACT;
                    sig_d   = SIG_SEED;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            COMPACT: begin
                if (pat_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + 4'd1;
                    err_d = err_upd;
                    if (cnt_q == LAST_PAT) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = DONE;
                pass_d  = verdict;
                fail_d  = !verdict;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SIG_SEED;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign busy      = (state_q == COMPACT) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign signature = sig_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench: three analyzer configurations share one random stimulus stream and are
// compared every cycle against a run-level reference model, plus literal directed checks.
module tb_bist_response_analyzer;

    logic clk = 1'b0;
    logic rst_n, start, pat_valid, sum, cout, exp_sum, exp_cout;

    logic [2:0] busy_w, done_w, pass_w, fail_w;
    logic [7:0] sig_w [3];
    logic [3:0] err_w [3];

    int  n_vec = 0;
    int  n_mis = 0;
    bit  checking = 1'b0;

    always #5 clk = ~clk;

    bist_response_analyzer #(.NUM_PATTERNS(8), .SIG_SEED(8'hFF), .GOLDEN_SIG(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .sum(sum), .cout(cout),
        .exp_sum(exp_sum), .exp_cout(exp_cout), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .fail(fail_w[0]), .signature(sig_w[0]), .err_count(err_w[0]));

    bist_response_analyzer #(.NUM_PATTERNS(1), .SIG_SEED(8'hFF), .GOLDEN_SIG(8'hFE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .sum(sum), .cout(cout),
        .exp_sum(exp_sum), .exp_cout(exp_cout), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .fail(fail_w[1]), .signature(sig_w[1]), .err_count(err_w[1]));

    bist_response_analyzer #(.NUM_PATTERNS(2), .SIG_SEED(8'hFF), .GOLDEN_SIG(8'hFD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .sum(sum), .cout(cout),
        .exp_sum(exp_sum), .exp_cout(exp_cout), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .fail(fail_w[2]), .signature(sig_w[2]), .err_count(err_w[2]));

    function automatic int np_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 1 : 2;
    endfunction

    function automatic logic [7:0] gold_of(input int k);
        return (k == 0) ? 8'h00 : (k == 1) ? 8'hFE : 8'hFD;
    endfunction

    // Shift up one place, then overwrite the two injection points.
    function automatic logic [7:0] misr(input logic [7:0] s, input logic sm, input logic co);
        logic [7:0] r;
        r    = s << 1;
        r[0] = (^(s & 8'b1011_1000)) ^ sm;
        r[1] = s[0] ^ co;
        return r;
    endfunction

    // Reference model: phase 0 idle, 1 collecting, 2 grading, 3 finished.
    int         ph   [3] = '{0, 0, 0};
    logic [7:0] msig [3] = '{8'hFF, 8'hFF, 8'hFF};
    int         mcnt [3] = '{0, 0, 0};
    int         merr [3] = '{0, 0, 0};
    bit         mpass[3] = '{0, 0, 0};
    bit         mfail[3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                ph[k] = 0; msig[k] = 8'hFF; mcnt[k] = 0; merr[k] = 0; mpass[k] = 0; mfail[k] = 0;
            end else begin
                case (ph[k])
                    0, 3: if (start) begin
                        ph[k] = 1; msig[k] = 8'hFF; mcnt[k] = 0; merr[k] = 0; mpass[k] = 0; mfail[k] = 0;
                    end
                    1: if (pat_valid) begin
                        msig[k] = misr(msig[k], sum, cout);
`ifdef BIST_ORA_CMP_EN
                        if ((sum != exp_sum || cout != exp_cout) && merr[k] < 15) merr[k]++;
`endif
                        mcnt[k]++;
                        if (mcnt[k] == np_of(k)) ph[k] = 2;
                    end
                    2: begin
                        mpass[k] = (msig[k] == gold_of(k)) && (merr[k] == 0);
                        mfail[k] = !mpass[k];
                        ph[k] = 3;
                        $display("run cfg%0d: signature=%h err=%0d pass=%0b t=%0t",
                                 k, msig[k], merr[k], mpass[k], $time);
                    end
                    default: ph[k] = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cfg%0d: got %h, expected %h at t=%0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                chk("busy", k, {7'd0, busy_w[k]}, {7'd0, (ph[k] == 1 || ph[k] == 2)});
                chk("done", k, {7'd0, done_w[k]}, {7'd0, (ph[k] == 3)});
                chk("pass", k, {7'd0, pass_w[k]}, {7'd0, mpass[k]});
                chk("fail", k, {7'd0, fail_w[k]}, {7'd0, mfail[k]});
                chk("signature", k, sig_w[k], msig[k]);
                chk("err_count", k, {4'd0, err_w[k]}, 8'(merr[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pat(input logic s, input logic c);
        pat_valid = 1'b1; sum = s; cout = c; exp_sum = s; exp_cout = c;
        step();
        pat_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pat_valid = 1'b0;
        sum = 1'b0; cout = 1'b0; exp_sum = 1'b0; exp_cout = 1'b0;

        // Pin the model's MISR step against hand-derived values.
        chk("model_ff_00", 0, misr(8'hFF, 1'b0, 1'b0), 8'hFE);
        chk("model_ff_10", 0, misr(8'hFF, 1'b1, 1'b0), 8'hFF);
        chk("model_fe_10", 0, misr(8'hFE, 1'b1, 1'b0), 8'hFD);

        step(); step();
        checking = 1'b1;
        chk("rst_sig", 0, sig_w[0], 8'hFF);
        chk("rst_busy", 0, {7'd0, busy_w[0]}, 8'd0);
        rst_n = 1'b1;

        // Single-pattern pass, and two-pattern run with a gap.
        start = 1'b1; step(); start = 1'b0;
        pat(1'b0, 1'b0);
        chk("np1_check_busy", 1, {7'd0, busy_w[1]}, 8'd1);
        chk("np1_check_done", 1, {7'd0, done_w[1]}, 8'd0);
        chk("np1_sig", 1, sig_w[1], 8'hFE);
        step();
        chk("np1_done", 1, {7'd0, done_w[1]}, 8'd1);
        chk("np1_pass", 1, {7'd0, pass_w[1]}, 8'd1);
        chk("np1_fail", 1, {7'd0, fail_w[1]}, 8'd0);
        chk("np2_mid_sig", 2, sig_w[2], 8'hFE);
        pat(1'b1, 1'b0);
        step();
        chk("np2_sig", 2, sig_w[2], 8'hFD);
        chk("np2_pass", 2, {7'd0, pass_w[2]}, 8'd1);

        // Sum stuck-at-1 on the single-pattern config.
        start = 1'b1; step(); start = 1'b0;
        pat(1'b1, 1'b0);
        step();
        chk("sa1_sig", 1, sig_w[1], 8'hFF);
        chk("sa1_fail", 1, {7'd0, fail_w[1]}, 8'd1);
        chk("sa1_pass", 1, {7'd0, pass_w[1]}, 8'd0);

        // Start during collection is ignored: 8 patterns still finish the run.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) pat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) pat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("restart_ignored_busy", 0, {7'd0, busy_w[0]}, 8'd1);
        step();
        chk("restart_ignored_done", 0, {7'd0, done_w[0]}, 8'd1);

        // Reset mid-run after three patterns.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) pat(1'b1, 1'b1);
        rst_n = 1'b0; start = 1'b1; step(); rst_n = 1'b1; start = 1'b0;
        chk("midrst_busy", 0, {7'd0, busy_w[0]}, 8'd0);
        chk("midrst_sig", 0, sig_w[0], 8'hFF);
        chk("midrst_err", 0, {4'd0, err_w[0]}, 8'd0);

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 2500; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            start     = ($urandom_range(0, 5) == 0);
            pat_valid = ($urandom_range(0, 3) != 0);
            sum       = 1'($urandom_range(0, 1));
            cout      = 1'($urandom_range(0, 1));
            exp_sum   = ($urandom_range(0, 4) == 0) ? ~sum : sum;
            exp_cout  = ($urandom_range(0, 4) == 0) ? ~cout : cout;
            step();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
